// File: rtl/matrix_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_pkg
// Description : Shared types and sizing helpers for the BCM matrix scan engine.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
package matrix_scan_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SHIFT_LO = 3'd1,
        ST_SHIFT_HI = 3'd2,
        ST_WAIT_OE  = 3'd3,
        ST_BLANK    = 3'd4,
        ST_LATCH    = 3'd5
    } scan_state_t;

    function automatic int col_width(input int columns);
        return $clog2(columns);
    endfunction

    function automatic int plane_width(input int bit_depth);
        return (bit_depth > 1) ? $clog2(bit_depth) : 1;
    endfunction

    // Widest weight is the MSB plane; one extra bit keeps the load value in range.
    function automatic int oe_timer_width(input int base_ticks, input int bit_depth);
        return $clog2(base_ticks << (bit_depth - 1)) + 1;
    endfunction

    function automatic int oe_weight(input int base_ticks, input int plane);
        return base_ticks << plane;
    endfunction

    localparam int DEFAULT_COL_W   = col_width(64);
    localparam int DEFAULT_PLANE_W = plane_width(6);
    localparam int DEFAULT_TMR_W   = oe_timer_width(16, 6);

endpackage
`default_nettype wire

// File: rtl/bcm_oe_timer.sv
`default_nettype none
// ============================================================================
// Module      : bcm_oe_timer
// Description : Output-enable period timer with per-plane gating for BCM.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module bcm_oe_timer #(
    parameter int BIT_DEPTH = 6,
    parameter int TMR_W     = 10,
    parameter int PLANE_W   = 3
) (
    input  logic                 clk_in,
    input  logic                 reset,
    input  logic                 load,
    input  logic [TMR_W-1:0]     load_value,
    input  logic [PLANE_W-1:0]   load_plane,
    input  logic [BIT_DEPTH-1:0] plane_enable,
    output logic                 output_enable,
    output logic                 expired
);

    logic [TMR_W-1:0]   r_count;
    logic [TMR_W-1:0]   w_next_count;
    logic [PLANE_W-1:0] r_plane;
    logic [PLANE_W-1:0] w_next_plane;

    always_comb begin
        w_next_count = r_count;
        w_next_plane = r_plane;
        if (load) begin
            w_next_count = load_value;
            w_next_plane = load_plane;
        end else if (r_count != '0) begin
            w_next_count = r_count - TMR_W'(1);
        end
    end

    // A gated-off plane still runs its full count so frame timing never changes.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_count       <= '0;
            r_plane       <= '0;
            output_enable <= 1'b0;
        end else begin
            r_count       <= w_next_count;
            r_plane       <= w_next_plane;
            output_enable <= (w_next_count != '0) && plane_enable[w_next_plane];
        end
    end

    assign expired = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/matrix_scan_bcm.sv
`default_nettype none
// ============================================================================
// Module      : matrix_scan_bcm
// Description : HUB75 scan engine: column/row addressing, shift clock, latch
//               and BCM-weighted output enable with shift/display overlap.
// Revision    : 1.0 - initial parametrised release
// ============================================================================
module matrix_scan_bcm
    import matrix_scan_pkg::*;
#(
    parameter int COLUMNS        = 64,
    parameter int ROW_ADDR_WIDTH = 4,
    parameter int BIT_DEPTH      = 6,
    parameter int OE_BASE_TICKS  = 16,
    parameter int BLANK_TICKS    = 2,
    parameter int LATCH_TICKS    = 1
) (
    input  logic                          clk_in,
    input  logic                          reset,
    input  logic                          enable,
    input  logic                          pixel_ready,
    input  logic [BIT_DEPTH-1:0]          plane_enable,
    output logic [col_width(COLUMNS)-1:0] column_address,
    output logic [ROW_ADDR_WIDTH-1:0]     row_address,
    output logic [ROW_ADDR_WIDTH-1:0]     row_address_active,
    output logic [BIT_DEPTH-1:0]          brightness_mask,
    output logic                          pixel_load_start,
    output logic                          clk_pixel,
    output logic                          row_latch,
    output logic                          output_enable,
    output logic                          frame_start
);

    localparam int COL_W    = col_width(COLUMNS);
    localparam int PLANE_W  = plane_width(BIT_DEPTH);
    localparam int TMR_W    = oe_timer_width(OE_BASE_TICKS, BIT_DEPTH);
    localparam int TICK_MAX = (BLANK_TICKS > LATCH_TICKS) ? BLANK_TICKS : LATCH_TICKS;
    localparam int TICK_W   = $clog2(TICK_MAX + 1);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(COLUMNS - 1);
    localparam logic [PLANE_W-1:0] PLANE_LAST = PLANE_W'(BIT_DEPTH - 1);

    scan_state_t         r_state;
    logic [PLANE_W-1:0]  r_plane;
    logic [PLANE_W-1:0]  r_latched_plane;
    logic [TICK_W-1:0]   r_tick;

    logic                w_last_plane;
    logic [PLANE_W-1:0]  w_next_plane;
    logic                w_oe_load;
    logic [TMR_W-1:0]    w_oe_value;
    logic                w_oe_expired;

    assign w_last_plane = (r_plane == PLANE_LAST);
    assign w_next_plane = w_last_plane ? '0 : r_plane + PLANE_W'(1);
    assign w_oe_load    = (r_state == ST_LATCH) && (r_tick == '0);
    assign w_oe_value   = TMR_W'(oe_weight(OE_BASE_TICKS, int'(r_latched_plane)));

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            r_state            <= ST_IDLE;
            r_plane            <= '0;
            r_latched_plane    <= '0;
            r_tick             <= '0;
            column_address     <= '0;
            row_address        <= '0;
            row_address_active <= '0;
            brightness_mask    <= '0;
            pixel_load_start   <= 1'b0;
            clk_pixel          <= 1'b0;
            row_latch          <= 1'b0;
            frame_start        <= 1'b0;
        end else begin
            pixel_load_start <= 1'b0;
            frame_start      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (enable) begin
                        r_state          <= ST_SHIFT_LO;
                        pixel_load_start <= 1'b1;
                        brightness_mask  <= BIT_DEPTH'(1) << r_plane;
                    end
                end
                ST_SHIFT_LO: begin
                    if (pixel_ready) begin
                        r_state   <= ST_SHIFT_HI;
                        clk_pixel <= 1'b1;
                    end
                end
                ST_SHIFT_HI: begin
                    clk_pixel <= 1'b0;
                    if (column_address == COL_LAST) begin
                        column_address <= '0;
                        r_state        <= ST_WAIT_OE;
                    end else begin
                        column_address <= column_address + COL_W'(1);
                        r_state        <= ST_SHIFT_LO;
                    end
                end
                ST_WAIT_OE: begin
                    if (w_oe_expired) begin
                        r_state <= ST_BLANK;
                        r_tick  <= TICK_W'(BLANK_TICKS - 1);
                    end
                end
                ST_BLANK: begin
                    if (r_tick == '0) begin
                        r_state            <= ST_LATCH;
                        r_tick             <= TICK_W'(LATCH_TICKS - 1);
                        row_latch          <= 1'b1;
                        row_address_active <= row_address;
                        r_latched_plane    <= r_plane;
                        frame_start        <= (row_address == '0) && (r_plane == '0);
                    end else begin
                        r_tick <= r_tick - TICK_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (r_tick == '0) begin
                        // OE timer loads on this same edge via w_oe_load.
                        row_latch <= 1'b0;
                        r_plane   <= w_next_plane;
                        if (w_last_plane) begin
                            row_address <= row_address + ROW_ADDR_WIDTH'(1);
                        end
                        if (enable) begin
                            r_state          <= ST_SHIFT_LO;
                            pixel_load_start <= 1'b1;
                            brightness_mask  <= BIT_DEPTH'(1) << w_next_plane;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_tick <= r_tick - TICK_W'(1);
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    bcm_oe_timer #(
        .BIT_DEPTH (BIT_DEPTH),
        .TMR_W     (TMR_W),
        .PLANE_W   (PLANE_W)
    ) u_oe_timer (
        .clk_in        (clk_in),
        .reset         (reset),
        .load          (w_oe_load),
        .load_value    (w_oe_value),
        .load_plane    (r_latched_plane),
        .plane_enable  (plane_enable),
        .output_enable (output_enable),
        .expired       (w_oe_expired)
    );

endmodule
`default_nettype wire

// File: tb/tb_matrix_scan_bcm.sv
`default_nettype none
// ============================================================================
// Module      : tb_matrix_scan_bcm
// Description : Directed self-checking bench for matrix_scan_bcm (4x2 rows, 2 planes).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_matrix_scan_bcm;

    logic       clk_in = 1'b0;
    logic       reset;
    logic       enable;
    logic       pixel_ready;
    logic [1:0] plane_enable;
    logic [1:0] column_address;
    logic [0:0] row_address;
    logic [0:0] row_address_active;
    logic [1:0] brightness_mask;
    logic       pixel_load_start;
    logic       clk_pixel;
    logic       row_latch;
    logic       output_enable;
    logic       frame_start;

    int checks   = 0;
    int failures = 0;

    matrix_scan_bcm #(
        .COLUMNS        (4),
        .ROW_ADDR_WIDTH (1),
        .BIT_DEPTH      (2),
        .OE_BASE_TICKS  (4),
        .BLANK_TICKS    (1),
        .LATCH_TICKS    (1)
    ) dut (
        .clk_in             (clk_in),
        .reset              (reset),
        .enable             (enable),
        .pixel_ready        (pixel_ready),
        .plane_enable       (plane_enable),
        .column_address     (column_address),
        .row_address        (row_address),
        .row_address_active (row_address_active),
        .brightness_mask    (brightness_mask),
        .pixel_load_start   (pixel_load_start),
        .clk_pixel          (clk_pixel),
        .row_latch          (row_latch),
        .output_enable      (output_enable),
        .frame_start        (frame_start)
    );

    always #5 clk_in = ~clk_in;

    // Event recorder: samples 1 time unit after each rising edge.
    int         cyc        = 0;
    int         oe_run     = 0;
    int         oe_total   = 0;
    int         pls_total  = 0;
    int         clkp_total = 0;
    int         overlap    = 0;
    logic       prev_latch = 1'b0;
    int         oe_widths[$];
    logic [1:0] latch_q[$];
    int         latch_cyc[$];
    int         latch_oe[$];

    initial begin
        forever begin
            @(posedge clk_in);
            #1;
            cyc++;
            if (output_enable) begin
                oe_run++;
                oe_total++;
            end else if (oe_run != 0) begin
                oe_widths.push_back(oe_run);
                oe_run = 0;
            end
            if (pixel_load_start) pls_total++;
            if (clk_pixel) clkp_total++;
            if (row_latch && output_enable) overlap++;
            if (row_latch && !prev_latch) begin
                latch_q.push_back({frame_start, row_address_active});
                latch_cyc.push_back(cyc);
                latch_oe.push_back(oe_total);
            end
            prev_latch = row_latch;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_in);
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_latches(input int n);
        for (int i = 0; i < 400 && latch_q.size() < n; i++) tick();
        check("latch_wait", 32'(latch_q.size() >= n), 1);
    endtask

    logic [7:0]  pat;
    logic [31:0] col_at;
    int          n_pls, n_clk, n, rel_cyc;
    bit          found;
    int          exp_w[4]     = '{4, 8, 4, 8};
    logic [1:0]  exp_latch[5] = '{2'b10, 2'b00, 2'b01, 2'b01, 2'b10};

    initial begin
        reset        = 1'b0;
        enable       = 1'b0;
        pixel_ready  = 1'b1;
        plane_enable = 2'b11;
        repeat (3) tick();
        check("reset_outputs", 32'({column_address, row_address, row_address_active, brightness_mask,
              pixel_load_start, clk_pixel, row_latch, output_enable, frame_start}), 0);

        // First plane: exact cycle timeline from the first enabled edge.
        @(negedge clk_in);
        reset  = 1'b1;
        enable = 1'b1;
        tick();
        check("start_pls", 32'(pixel_load_start), 1);
        check("start_mask", 32'(brightness_mask), 1);
        pat    = '0;
        col_at = '0;
        for (int i = 0; i < 8; i++) begin
            tick();
            pat = {pat[6:0], clk_pixel};
            if (i == 6) col_at = 32'(column_address);
        end
        check("clk_pixel_pattern", 32'(pat), 32'hAA);
        check("last_column", col_at, 3);
        check("column_wrap", 32'(column_address), 0);
        tick();
        check("blank", 32'({row_latch, output_enable}), 0);
        tick();
        check("latch_frame", 32'({row_latch, frame_start, output_enable}), 3'b110);
        tick();
        check("after_latch", 32'({row_latch, output_enable, pixel_load_start, brightness_mask}), 5'b01110);

        // Free run: row/frame sequence, OE weights, latch spacing.
        wait_latches(5);
        for (int k = 0; k < 5; k++)
            check("latch_seq", 32'((k < latch_q.size()) ? latch_q[k] : 2'bxx), 32'(exp_latch[k]));
        for (int k = 0; k < 4; k++)
            check("oe_width", (k < oe_widths.size()) ? 32'(oe_widths[k]) : 32'hFFFF_FFFF, exp_w[k]);
        check("free_spacing", 32'(latch_cyc[4] - latch_cyc[0]), 44);

        // Stall the shift at column 2 for three cycles.
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            tick();
            found = (column_address == 2'd2) && (clk_pixel == 1'b0);
        end
        check("stall_reach", 32'(found), 1);
        pixel_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("stall_hold", 32'({clk_pixel, column_address}), 3'b010);
        end
        pixel_ready = 1'b1;
        tick();
        check("stall_release", 32'({clk_pixel, column_address}), 3'b110);

        // Plane 1 gated off from here on.
        plane_enable = 2'b01;
        wait_latches(6);
        check("stall_spacing", 32'(latch_cyc[5] - latch_cyc[4]), 14);
        wait_latches(8);
        check("gated_oe_p1", 32'(latch_oe[6] - latch_oe[5]), 0);
        check("gated_oe_p0", 32'(latch_oe[7] - latch_oe[6]), 4);
        check("gated_spacing_a", 32'(latch_cyc[6] - latch_cyc[5]), 11);
        check("gated_spacing_b", 32'(latch_cyc[7] - latch_cyc[6]), 11);
        plane_enable = 2'b11;

        // Drop enable during the shift of row 1 plane 0.
        wait_latches(10);
        repeat (3) tick();
        enable = 1'b0;
        wait_latches(11);
        check("drop_latch", 32'(latch_q[10]), 2'b01);
        n_pls = pls_total;
        n_clk = clkp_total;
        repeat (20) tick();
        check("idle_no_pls", 32'(pls_total - n_pls), 0);
        check("idle_no_clk", 32'(clkp_total - n_clk), 0);
        check("idle_last_oe", 32'(oe_widths[oe_widths.size() - 1]), 4);
        check("idle_no_latch", 32'(latch_q.size()), 11);
        check("idle_hold", 32'({output_enable, row_address}), 2'b01);

        enable = 1'b1;
        tick();
        check("resume", 32'({pixel_load_start, brightness_mask, row_address}), 4'b1101);
        wait_latches(12);
        check("resume_latch", 32'(latch_q[11]), 2'b01);

        // Reset while latching row 0 plane 1.
        wait_latches(14);
        check("pre_reset_latch", 32'(row_latch), 1);
        #1;
        reset = 1'b0;
        #1;
        check("async_reset", 32'({row_latch, output_enable, clk_pixel, pixel_load_start,
              frame_start, brightness_mask}), 0);
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        n       = latch_q.size();
        rel_cyc = cyc;
        reset   = 1'b1;
        wait_latches(n + 1);
        check("post_reset_latch", 32'(latch_q[n]), 2'b10);
        check("post_reset_timing", 32'(latch_cyc[n] - rel_cyc), 11);
        check("no_oe_latch_overlap", 32'(overlap), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/matrix_scan_bcm.md
Name: matrix_scan_bcm

Overview:
Parametrised successor to the fixed 64x32, 6-bit scan engine in the LED matrix driver. It generates column/row addressing, pixel clock, row latch and output-enable for HUB75-style panels of configurable width, scan depth and bit depth. Output-enable uses binary-coded-modulation (BCM) timing weighted per bit plane. Shifting of the next plane overlaps display of the current one, with a ready handshake toward framebuffer fetch. It sits between the matrix clock divider and the framebuffer_fetch / pixel_split path.

Parameters:
COLUMNS, 64, pixels shifted per row per plane (≥2)
ROW_ADDR_WIDTH, 4, scan row address width (scan rows = 2^ROW_ADDR_WIDTH)
BIT_DEPTH, 6, bit planes per pixel channel (1..8)
OE_BASE_TICKS, 16, clk_in cycles OE is active for plane 0 (LSB)
BLANK_TICKS, 2, OE-low guard cycles before latch (≥1)
LATCH_TICKS, 1, cycles row_latch is held high (≥1)

Ports:
clk_in  in  1  matrix clock
reset  in  1  asynchronous, active-low reset
enable  in  1  run request; sampled only at plane boundaries
pixel_ready  in  1  fetch path has data valid for column_address
plane_enable  in  BIT_DEPTH  per-plane OE gate (global dimming)
column_address  out  clog2(COLUMNS)  column being shifted
row_address  out  ROW_ADDR_WIDTH  row being shifted
row_address_active  out  ROW_ADDR_WIDTH  row currently displayed (drives A..D)
brightness_mask  out  BIT_DEPTH  one-hot plane being shifted
pixel_load_start  out  1  one-cycle pulse at start of each plane shift
clk_pixel  out  1  panel shift clock
row_latch  out  1  panel latch
output_enable  out  1  active-high OE (top level inverts)
frame_start  out  1  one-cycle pulse when row 0 plane 0 latches

Behaviour:
- Reset (async, reset=0): all outputs 0; state IDLE; row=0, plane=0, column=0; OE timer cleared.
- Scan order: plane-major within row: (row r, plane 0..BIT_DEPTH-1), then r+1; row wraps 2^ROW_ADDR_WIDTH-1 -> 0.
- Shift FSM states: IDLE, SHIFT_LO, SHIFT_HI, WAIT_OE, BLANK, LATCH.
- IDLE: if enable=1 -> SHIFT_LO next cycle with pixel_load_start=1 for that one cycle; brightness_mask=1<<plane.
- SHIFT_LO: clk_pixel=0; if pixel_ready=1 -> SHIFT_HI, else stall in SHIFT_LO (clk_pixel stays 0).
- SHIFT_HI: clk_pixel=1 one cycle; if column=COLUMNS-1 -> WAIT_OE, column=0; else column+1 -> SHIFT_LO.
- Minimum shift time per plane: 2*COLUMNS cycles.
- WAIT_OE: waits until OE timer expired (OE already 0); then BLANK.
- BLANK: OE=0 for BLANK_TICKS cycles -> LATCH.
- LATCH: row_latch=1 for LATCH_TICKS cycles. On the first LATCH cycle: row_address_active<=row_address; latched plane p recorded; frame_start=1 if row=0 and p=0.
- Leaving LATCH: OE timer loads OE_BASE_TICKS<<p. The shift position advances to the next (plane, row). If enable=1 -> SHIFT_LO with pixel_load_start pulse; else IDLE.
- OE: output_enable=1 while timer>0 and plane_enable[p]=1, decrementing each cycle. If plane_enable[p]=0 the timer still counts but OE stays 0, so frame timing is invariant.
- OE timer width: clog2(OE_BASE_TICKS<<(BIT_DEPTH-1))+1; no overflow permitted.
- Overlap: shift of the next plane runs concurrently with OE of the current plane. If the shift finishes first, wait in WAIT_OE. If OE expires first, OE stays 0 until BLANK/LATCH complete.
- output_enable and row_latch are never simultaneously 1. OE is 0 throughout BLANK and LATCH.
- enable falling mid-plane: the current shift/latch completes, the OE period runs out, then IDLE with all strobes 0. Addresses are held, so resume continues the sequence.
- Reset mid-operation: immediate return to reset values; no partial latch is emitted after reset release.
- All outputs registered; no combinational path from inputs to outputs.

Decomposition:
- Package matrix_scan_pkg: state enum, clog2-derived localparams (column width, OE timer width), and the OE weight function (base<<plane).
- Sub-module bcm_oe_timer: load/count/expired logic plus plane_enable gating. The FSM, addressing and latch live in the top.

Test Plan:
All scenarios use COLUMNS=4, ROW_ADDR_WIDTH=1, BIT_DEPTH=2, OE_BASE_TICKS=4, BLANK=1, LATCH=1, unless stated.
- Reset then enable=1, pixel_ready=1 -> pixel_load_start at cycle 1; 4 clk_pixel high pulses on alternate cycles; BLANK 1 cycle; row_latch 1 cycle; frame_start coincident; OE high 4 cycles (plane 0).
- Free run -> OE high widths repeat 4,8,4,8. row_address_active sequence 0,0,1,1,0. frame_start every 4 latches.
- pixel_ready low 3 cycles at column 2 -> clk_pixel held low 3 extra cycles; column_address stays 2; no latch until shift completes.
- plane_enable=2'b01 -> plane-1 periods show OE=0 for 8 cycles; latch spacing is identical to the all-enabled case.
- enable dropped mid-shift of row 1 plane 0 -> that plane latches, OE 4 cycles, then IDLE. Re-enable resumes at row 1 plane 1.
- Reset asserted during LATCH -> row_latch, output_enable and clk_pixel go 0 asynchronously; after release, first latch is row 0 plane 0 with frame_start.
